sr_pipo_4bit: RTL and testbench

//   4-bit parallel-in/parallel-out register; one clock, synchronous active-high reset.
//   - Captures the full input word on each rising clock edge.
//   - Presents the word at the output one cycle later.
//   - Used as a pipeline/holding stage between datapath blocks; no shifting, no enable.

---
 rtl/sr_pipo_4bit.sv | 58 +++++
 tb/tb_sr_pipo_4bit.sv | 109 ++++++++++
 2 files changed

// File: rtl/sr_pipo_4bit.sv
// -----------------------------------------------------------------------------
// sr_pipo_4bit
//
// Purpose:
//   Parallel-in/parallel-out holding register used as a pipeline stage between
//   datapath blocks. The whole input word is captured on every rising clock
//   edge and presented on the output for the following cycle. There is no
//   shifting and no load enable. A synchronous active-high reset forces the
//   output to RST_VAL and takes priority over the load.
//
// Parameters:
//   WIDTH    data width in bits (4 is the verified configuration)
//   RST_VAL  value loaded into dout by reset
//
// Ports (declaration order is fixed; existing instances connect by position):
//   din   in   WIDTH  parallel data input
//   clk   in   1      clock, all state changes on the rising edge
//   rst   in   1      synchronous active-high reset, sampled only at posedge clk
//   dout  out  WIDTH  registered parallel data output
// -----------------------------------------------------------------------------
module sr_pipo_4bit #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic [WIDTH-1:0] din,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] dout_d;

   // Next-state is simply the incoming word; the reset override lives in the
   // register so that it can only ever act at a clock edge.
   always_comb begin
      // NOTE: give every always_comb output an unconditional value first so no
      // path through the block leaves it unassigned and a latch is inferred.
      dout_d = din;
   end

   // Reset is sampled with the clock: a pulse that starts and ends between two
   // rising edges is never seen, and reset wins over the load when both apply.
   always_ff @(posedge clk) begin
      // NOTE: registers are written with non-blocking assignments so every
      // flop samples its inputs from before the edge, regardless of order.
      if (rst) begin
         dout_q <= RST_VAL;
      end else begin
         dout_q <= dout_d;
      end
   end

   // Output comes straight from the flops: no combinational din->dout path,
   // all bits change together and only just after a rising edge.
   assign dout = dout_q;

endmodule

// File: tb/tb_sr_pipo_4bit.sv
// -----------------------------------------------------------------------------
// tb_sr_pipo_4bit
//
// Purpose:
//   Self-checking bench for sr_pipo_4bit. Directed stimulus is placed at
//   absolute times on a 50-unit clock (rising edges at 25, 75, 125, ...), and
//   dout is sampled well away from the rising edges against hand-computed
//   expected words.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sr_pipo_4bit;

   logic [3:0] din;
   logic       clk;
   logic       rst;
   logic [3:0] dout;

   int checks   = 0;
   int failures = 0;

   sr_pipo_4bit #(
      .WIDTH   (4),
      .RST_VAL (4'h0)
   ) dut (
      .din  (din),
      .clk  (clk),
      .rst  (rst),
      .dout (dout)
   );

   // Rising edges at t = 25, 75, 125, ...
   initial begin
      clk = 1'b0;
      forever #25 clk = ~clk;
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: dout=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   // Advance to an absolute simulation time.
   task automatic at(input longint t);
      #(t - longint'($time));
   endtask

   initial begin
      din = 4'b0101;
      rst = 1'b0;

      // Reset pulse entirely between edges 25 and 75... actually before edge 25
      at(10);  rst = 1'b1;
      at(20);  rst = 1'b0;

      // Load at edge 25; the sub-cycle pulse must not have cleared anything.
      at(30);  check("load_0101", dout, 4'b0101);
      at(50);  check("subcycle_rst_ignored", dout, 4'b0101);

      // Synchronous reset asserted mid-cycle, with non-zero din present.
      at(60);  din = 4'b0011; rst = 1'b1;
      at(70);  check("rst_not_async", dout, 4'b0101);
      at(80);  check("sync_rst", dout, 4'b0000);

      // Release before edge 125; first load happens at that edge, no dead cycle.
      at(90);  rst = 1'b0;
      at(100); check("rst_release_hold", dout, 4'b0000);
      at(130); check("first_load_after_rst", dout, 4'b0011);

      // Mid-cycle din changes appear only after the following edge.
      at(150); din = 4'b1101;
      at(151); check("no_change_at_150", dout, 4'b0011);
      at(180); check("update_1101", dout, 4'b1101);
      at(210); din = 4'b0111;
      at(211); check("no_change_at_210", dout, 4'b1101);
      at(230); check("update_0111", dout, 4'b0111);

      // Hold over edges 275, 325, 375 with glitches on din between edges.
      at(240); din = 4'b1010;
      at(245); din = 4'b0111;
      at(260); check("glitch_not_passed", dout, 4'b0111);
      at(280); check("hold_edge_275", dout, 4'b0111);
      at(290); din = 4'b1000;
      at(300); din = 4'b0111;
      at(330); check("hold_edge_325", dout, 4'b0111);
      at(380); check("hold_edge_375", dout, 4'b0111);

      // Whole-word updates: all ones, then all zeros.
      at(390); din = 4'b1111;
      at(430); check("all_ones", dout, 4'b1111);
      at(440); din = 4'b0000;
      at(480); check("all_zeros", dout, 4'b0000);

      // Reset priority over a pending non-zero load, then immediate reload.
      at(485); din = 4'b1111;
      at(490); din = 4'b1010; rst = 1'b1;
      at(520); check("pre_rst_load", dout, 4'b0000);
      at(530); check("rst_priority", dout, 4'b0000);
      at(540); rst = 1'b0;
      at(580); check("reload_after_rst", dout, 4'b1010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
